data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 13 +
 rtl/mem_arb_rr.sv | 15 +
 rtl/data_mem_arbiter.sv | 119 +++++++++++
 tb/tb_data_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the two-port data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a core port and a debug/DMA port onto one single-cycle data memory,
// with lock support for read-modify-write sequences and one-cycle read return.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_memw,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    arb_state_e state;
    logic       last_grant;
    logic       rr_winner;
    logic       rr_valid;

    mem_arb_rr u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .winner     (rr_winner),
        .valid      (rr_valid)
    );

    // Grants are gated by rst_n so nothing reaches memory while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state)
                ARB: begin
                    gnt0 = rr_valid & ~rr_winner;
                    gnt1 = rr_valid & rr_winner;
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_memw       = 1'b0;
        mem_address    = '0;
        mem_data_write = '0;
        if (gnt0) begin
            mem_memw       = we0;
            mem_address    = addr0;
            mem_data_write = wdata0;
        end else if (gnt1) begin
            mem_memw       = we1;
            mem_address    = addr1;
            mem_data_write = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            last_grant <= 1'b1;
        end else begin
            if (gnt0)
                last_grant <= 1'b0;
            else if (gnt1)
                last_grant <= 1'b1;

            case (state)
                ARB: begin
                    if (gnt0 && lock0)
                        state <= LOCK0;
                    else if (gnt1 && lock1)
                        state <= LOCK1;
                end
                LOCK0:   if (!req0 || !lock0) state <= ARB;
                LOCK1:   if (!req1 || !lock1) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    // Read return stage: capture memory data at the closing edge of the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0)
                rdata0 <= mem_data_read;
            if (gnt1 && !we1)
                rdata1 <= mem_data_read;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: drives per-cycle requests with expected grants,
// queues expected read data on grant and checks it when rvalid returns.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_memw;
    logic [31:0] mem_address, mem_data_write, mem_data_read;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .lock0          (lock0),
        .lock1          (lock1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_memw       (mem_memw),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read)
    );

    // Single-cycle data memory model
    assign mem_data_read = mem[mem_address[5:2]];
    always @(posedge clk)
        if (mem_memw) mem[mem_address[5:2]] <= mem_data_write;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Read-return monitor: every queued read must come back exactly one cycle after grant
    always @(negedge clk) begin
        if (rvalid0 || q0.size() != 0) begin
            chk("rvalid0", 32'(rvalid0), 32'(q0.size() != 0));
            if (q0.size() != 0) chk("rdata0", rdata0, q0.pop_front());
        end
        if (rvalid1 || q1.size() != 0) begin
            chk("rvalid1", 32'(rvalid1), 32'(q1.size() != 0));
            if (q1.size() != 0) chk("rdata1", rdata1, q1.pop_front());
        end
    end

    task automatic set_idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    // One cycle, entered and left at a falling edge
    task automatic cyc(input logic r0, w0, l0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1,
                       input logic eg0, eg1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #1;
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        if (eg0) begin
            chk("mem_address", mem_address, a0);
            chk("mem_memw", 32'(mem_memw), 32'(w0));
            if (w0) begin
                chk("mem_data_write", mem_data_write, d0);
                ref_mem[a0[5:2]] = d0;
            end else q0.push_back(ref_mem[a0[5:2]]);
        end else if (eg1) begin
            chk("mem_address", mem_address, a1);
            chk("mem_memw", 32'(mem_memw), 32'(w1));
            if (w1) begin
                chk("mem_data_write", mem_data_write, d1);
                ref_mem[a1[5:2]] = d1;
            end else q1.push_back(ref_mem[a1[5:2]]);
        end else begin
            chk("idle_memw", 32'(mem_memw), 32'd0);
            chk("idle_address", mem_address, 32'd0);
            chk("idle_wdata", mem_data_write, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        set_idle();
        rst_n = 1'b0;
        req0 = 1; req1 = 1; we0 = 1; addr0 = 32'h4; wdata0 = 32'h1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_memw", 32'(mem_memw), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_mem4", mem[1], 32'd0);
        @(negedge clk);
        do_reset();

        // Idle cycle
        cyc(0,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         0,0);

        // Write via port 0, read back via port 1, then port 1 write leaves rdata1 alone
        cyc(1,1,0,32'h4,32'hDEADBEEF,     0,0,0,32'h0,32'h0,         1,0);
        cyc(0,0,0,32'h0,32'h0,            1,0,0,32'h4,32'h0,         0,1);
        cyc(0,0,0,32'h0,32'h0,            1,1,0,32'h10,32'h55,       0,1);
        chk("rdata1_hold", rdata1, 32'hDEADBEEF);

        // Locked read-modify-write on port 1 while port 0 waits
        cyc(1,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         1,0);
        cyc(1,0,0,32'h0,32'h0,            1,0,1,32'h8,32'h0,         0,1);
        cyc(1,0,0,32'h0,32'h0,            1,1,0,32'h8,32'h12345679,  0,1);
        cyc(1,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         1,0);
        cyc(0,0,0,32'h0,32'h0,            1,0,0,32'h8,32'h0,         0,1);

        // Lock owner withdraws its request
        cyc(0,0,0,32'h0,32'h0,            1,0,1,32'h8,32'h0,         0,1);
        cyc(1,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         0,0);
        cyc(1,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         1,0);

        // Port 0 lock blocks port 1
        cyc(1,0,1,32'h4,32'h0,            0,0,0,32'h0,32'h0,         1,0);
        cyc(1,1,0,32'h0,32'hA5A5A5A5,     1,0,0,32'h4,32'h0,         1,0);
        cyc(0,0,0,32'h0,32'h0,            1,0,0,32'h0,32'h0,         0,1);

        // Both requesting reads from reset: strict alternation starting with port 0
        do_reset();
        for (int i = 0; i < 6; i++)
            cyc(1,0,0,32'h4,32'h0,        1,0,0,32'h8,32'h0,
                1'((i % 2) == 0), 1'((i % 2) == 1));

        // Reset asserted during a locked write
        do_reset();
        cyc(0,0,0,32'h0,32'h0,            1,0,1,32'hC,32'h0,         0,1);
        req0 = 1; we0 = 0; lock0 = 0; addr0 = 32'h0;
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'hC; wdata1 = 32'hFFFFFFFF;
        #1;
        chk("lockwr_gnt1", 32'(gnt1), 32'd1);
        chk("lockwr_memw", 32'(mem_memw), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt0", 32'(gnt0), 32'd0);
        chk("midrst_gnt1", 32'(gnt1), 32'd0);
        chk("midrst_memw", 32'(mem_memw), 32'd0);
        chk("midrst_rvalid1", 32'(rvalid1), 32'd0);
        chk("midrst_rdata0", rdata0, 32'd0);
        chk("midrst_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        chk("mem_c_kept", mem[3], 32'd0);
        set_idle();
        @(negedge clk);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        cyc(1,0,0,32'h4,32'h0,            1,0,0,32'hC,32'h0,         1,0);
        cyc(0,0,0,32'h0,32'h0,            0,0,0,32'h0,32'h0,         0,0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
